// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v scan counters, registered syncs.
// Define VGA_SYNC_ACTIVE_HIGH_EN for active-high hsync/vsync (reset value 0).
module vga_sync_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_DISP);
    localparam logic [9:0] V_VIS     = 10'(V_DISP);
    localparam logic [9:0] H_SYNC_LO = 10'(H_DISP + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_LO = 10'(V_DISP + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_DISP + V_FP + V_SYNC);

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif
    localparam logic SYNC_OFF = ~SYNC_ON;

    function automatic logic sync_level(input logic [9:0] pos,
                                        input logic [9:0] lo,
                                        input logic [9:0] hi);
        return ((pos >= lo) && (pos < hi)) ? SYNC_ON : SYNC_OFF;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;

    assign pixel_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (pixel_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        h_nxt = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Status outputs are decoded from the next position so they line up with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            valid       <= 1'b0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            frame_start <= 1'b0;
        end else if (pixel_tick) begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            valid       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            hsync       <= sync_level(h_nxt, H_SYNC_LO, H_SYNC_HI);
            vsync       <= sync_level(v_nxt, V_SYNC_LO, V_SYNC_HI);
            frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: two reduced-timing instances (CLK_DIV=3 and CLK_DIV=1)
// checked every cycle against a clocks-since-reset arithmetic model of the raster.
module tb_vga_sync_gen;

    typedef struct {
        logic       tick;
        logic [9:0] h;
        logic [9:0] v;
        logic       vld;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
    } exp_t;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    localparam bit ACT_HIGH = 1'b1;
`else
    localparam bit ACT_HIGH = 1'b0;
`endif

    logic clk;
    logic rst_n;

    logic       a_tick, a_vld, a_hs, a_vs, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_tick, b_vld, b_hs, b_vs, b_fs;
    logic [9:0] b_h, b_v;

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISP(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_tick(a_tick), .h_cnt(a_h), .v_cnt(a_v),
        .valid(a_vld), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISP(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .pixel_tick(b_tick), .h_cnt(b_h), .v_cnt(b_v),
        .valid(b_vld), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   e        = 0;

    // Expected outputs after e clock edges since reset release.
    function automatic obs_t model(input int edges, input int cd,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb);
        obs_t o;
        int ht, vt, ticks, p, h, v;
        bit hwin, vwin;
        ht    = hd + hf + hsw + hb;
        vt    = vd + vf + vsw + vb;
        ticks = edges / cd;
        o.tick = ((edges % cd) == cd - 1);
        if (ticks == 0) begin
            h = ht - 1;
            v = vt - 1;
            o.vld = 1'b0;
            o.fs  = 1'b0;
            hwin  = 1'b0;
            vwin  = 1'b0;
        end else begin
            p = (ticks - 1) % (ht * vt);
            h = p % ht;
            v = p / ht;
            o.vld = (h < hd) && (v < vd);
            o.fs  = (p == 0) && ((edges % cd) == 0);
            hwin  = (h >= hd + hf) && (h < hd + hf + hsw);
            vwin  = (v >= vd + vf) && (v < vd + vf + vsw);
        end
        o.h  = 10'(h);
        o.v  = 10'(v);
        o.hs = ACT_HIGH ? hwin : !hwin;
        o.vs = ACT_HIGH ? vwin : !vwin;
        return o;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic compare(input string tag, input obs_t act, input obs_t req);
        check({tag, ".pixel_tick"},  int'(act.tick), int'(req.tick));
        check({tag, ".h_cnt"},       int'(act.h),    int'(req.h));
        check({tag, ".v_cnt"},       int'(act.v),    int'(req.v));
        check({tag, ".valid"},       int'(act.vld),  int'(req.vld));
        check({tag, ".hsync"},       int'(act.hs),   int'(req.hs));
        check({tag, ".vsync"},       int'(act.vs),   int'(req.vs));
        check({tag, ".frame_start"}, int'(act.fs),   int'(req.fs));
    endtask

    // One cycle of stimulus: r=0 holds/asserts reset (asynchronously, between edges).
    task automatic step(input logic r);
        exp_t x;
        @(posedge clk);
        #1;
        if (!r) begin
            rst_n = 1'b0;
            e = 0;
        end else if (!rst_n) begin
            rst_n = 1'b1;
            e = 0;
        end else begin
            e++;
        end
        x.a = model(e, 3, 16, 2, 4, 3, 6, 1, 2, 2);
        x.b = model(e, 1, 8, 1, 2, 1, 4, 1, 1, 1);
        exp_q.push_back(x);
    endtask

    // Monitor: every cycle the DUTs present a position, compare against the oldest expectation.
    initial begin
        exp_t x;
        obs_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                act.tick = a_tick; act.h = a_h; act.v = a_v; act.vld = a_vld;
                act.hs = a_hs; act.vs = a_vs; act.fs = a_fs;
                compare("a", act, x.a);
                act.tick = b_tick; act.h = b_h; act.v = b_v; act.vld = b_vld;
                act.hs = b_hs; act.vs = b_vs; act.fs = b_fs;
                compare("b", act, x.b);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) step(1'b0);
        for (int seg = 0; seg < 4; seg++) begin
            // First segment spans two full frames of the larger instance; later ones cut in randomly.
            n = (seg == 0) ? 1700 : 200 + int'($urandom_range(0, 1400));
            repeat (n) step(1'b1);
            repeat (1 + int'($urandom_range(0, 2))) step(1'b0);
        end
        repeat (900) step(1'b1);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
